item_memory_loader: RTL
=======================

ITEM_MEMORY_LOADER -- requirements
Module: item_memory_loader

Interface
REQ-001 SHALL have parameter AddrWidth, default 10, item-memory address width (depth 2^AddrWidth).
REQ-002 SHALL have parameter DataWidth, default 512, hypervector width in bits.
REQ-003 SHALL have ports (clock and reset first):
- clk_i  input  1  clock; one clock, all state on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  begin a load session.
- clr_i  input  1  synchronous abort/clear to IDLE.
- num_entries_i  input  AddrWidth+1  entries to load; sampled on accepted start.
- data_i  input  DataWidth  incoming hypervector.
- data_valid_i  input  1  data_i valid.
- data_ready_o  output  1  loader accepts data_i.
- mem_wr_en_o  output  1  item-memory write strobe.
- mem_wr_addr_o  output  AddrWidth  item-memory write address.
- mem_wr_data_o  output  DataWidth  item-memory write data.
- busy_o  output  1  high in LOAD.
- done_o  output  1  high in DONE.
- count_o  output  AddrWidth+1  entries written in current session.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-005 IDLE: data_ready_o=0; start_i=1 with num_entries_i>0 -> LOAD next cycle, latch num_entries_i, address counter and count_o cleared to 0.
REQ-006 IDLE: start_i=1 with num_entries_i=0 -> DONE next cycle, count_o=0, no writes.
REQ-007 LOAD: data_ready_o=1 combinationally; handshake = data_valid_i & data_ready_o.
REQ-008 mem_wr_en_o SHALL equal the handshake in the same cycle (zero latency); mem_wr_data_o = data_i, mem_wr_addr_o = current address register.
REQ-009 Each handshake SHALL increment address register and count_o by 1 at the next edge; no handshake -> hold.
REQ-010 Handshake with count_o = latched num - 1 -> DONE next cycle; count_o then equals latched num.
REQ-011 Address register SHALL wrap from 2^AddrWidth-1 to 0; with num = 2^AddrWidth the final write targets address 2^AddrWidth-1 and count_o reaches 2^AddrWidth without overflow.
REQ-012 start_i during LOAD SHALL be ignored; num_entries_i changes during LOAD SHALL be ignored.
REQ-013 DONE: data_ready_o=0, mem_wr_en_o=0, count_o and address held; start_i -> new session as in REQ-005/006.
REQ-014 clr_i=1 SHALL have priority over start_i and handshakes in every state: next state IDLE, address and count_o 0, mem_wr_en_o forced 0 in that cycle, data_ready_o 0 in that cycle.
REQ-015 mem_wr_en_o SHALL never assert outside LOAD.
REQ-016 busy_o = (state==LOAD), done_o = (state==DONE), both registered-state decodes.
REQ-017 mem_wr_data_o SHALL be driven from data_i unconditionally (don't-care when mem_wr_en_o=0).

Reset
REQ-018 rst_i=1 SHALL asynchronously force IDLE, address 0, count_o 0, latched num 0.
REQ-019 During and after reset until next start: data_ready_o=0, mem_wr_en_o=0, busy_o=0, done_o=0, count_o=0, mem_wr_addr_o=0.
REQ-020 rst_i asserted mid-LOAD SHALL abort immediately; no write strobe while rst_i=1.

Verification
REQ-021 Start num=4, valid held high 4 cycles -> writes to addr 0,1,2,3 in consecutive cycles, done_o next cycle, count_o=4.
REQ-022 Start num=3, valid toggled 1,0,1,0,1 -> exactly 3 writes at addr 0,1,2 only on valid cycles, then DONE.
REQ-023 Start num=0 -> DONE next cycle, zero writes, count_o=0.
REQ-024 AddrWidth=3, num=8 -> addr 0..7, count_o=8, done_o=1; restart with num=2 -> addr 0,1.
REQ-025 clr_i asserted after 2 of 5 writes, same cycle as valid -> no write that cycle, IDLE next, count_o=0; rst_i mid-LOAD -> outputs per REQ-019 immediately.
REQ-026 start_i pulsed mid-LOAD with different num -> ignored, session completes at original num.

Source files
------------

// File: rtl/item_memory_loader.sv
// Streams hypervectors into an item memory: one write per valid/ready handshake,
// sequential addresses from 0, stopping after a latched number of entries.
module item_memory_loader #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 clr_i,
    input  logic [AddrWidth:0]   num_entries_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    output logic                 mem_wr_en_o,
    output logic [AddrWidth-1:0] mem_wr_addr_o,
    output logic [DataWidth-1:0] mem_wr_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth:0]   count_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AddrWidth-1:0] ADDR_ONE  = 1;
    localparam logic [AddrWidth:0]   COUNT_ONE = 1;

    logic [1:0]           state_reg, state_next;
    logic [AddrWidth-1:0] addr_reg, addr_next;
    logic [AddrWidth:0]   count_reg, count_next;
    logic [AddrWidth:0]   num_reg, num_next;
    logic                 handshake;

    // clr_i masks ready so an aborting cycle can never produce a write.
    assign data_ready_o  = (state_reg == LOAD) && !clr_i;
    assign handshake     = data_valid_i && data_ready_o;
    assign mem_wr_en_o   = handshake;
    assign mem_wr_addr_o = addr_reg;
    assign mem_wr_data_o = data_i;
    assign busy_o        = (state_reg == LOAD);
    assign done_o        = (state_reg == DONE);
    assign count_o       = count_reg;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        num_next   = num_reg;
        if (clr_i) begin
            state_next = IDLE;
            addr_next  = '0;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_i) begin
                        num_next   = num_entries_i;
                        addr_next  = '0;
                        count_next = '0;
                        state_next = (num_entries_i == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        // Address is AddrWidth bits and wraps; count is one bit wider.
                        addr_next  = addr_reg + ADDR_ONE;
                        count_next = count_reg + COUNT_ONE;
                        if (count_reg == num_reg - COUNT_ONE) begin
                            state_next = DONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            num_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
            num_reg   <= num_next;
        end
    end

endmodule
